// File: rtl/trace_reader.sv
// trace_reader: draws the captured trace, trigger-level line and grid in step with the VGA scan.
// Define TRACE_INTERP_EN to join adjacent samples with vertical runs instead of single dots.
module trace_reader #(
   parameter int ADDR_W   = 10,
   parameter int DEPTH    = 512,
   parameter int RD_LAT   = 1,
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int TOP      = 112,
   parameter int GRID     = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [9:0]        x,
   input  logic [9:0]        y,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [7:0]        rd_data,
   input  logic [7:0]        level,
   input  logic              capture_ready,
   output logic              hold_capture,
   output logic              capture_ack,
   output logic [2:0]        rgb
);
   localparam logic [1:0] S_EMPTY = 2'd0;
   localparam logic [1:0] S_SHOW  = 2'd1;
   localparam logic [1:0] S_ACK   = 2'd2;
   localparam int P = RD_LAT + 1;
   localparam logic [9:0] DEPTH_V = 10'(DEPTH);
   localparam logic [9:0] H_V     = 10'(H_ACTIVE);
   localparam logic [9:0] V_V     = 10'(V_ACTIVE);
   localparam logic [9:0] GRID_V  = 10'(GRID);
   localparam logic [9:0] BASE_V  = 10'(TOP + 255);

   logic [1:0]   state;
   logic [9:0]   xd [P];
   logic [9:0]   yd [P];
   logic [P-1:0] vld;
   logic [9:0]   xs, ys, cur, lvl_row;
   logic         frame_start, frame_end, hit, trace, vis, grid;
   logic [2:0]   pix;

   assign frame_start = x == 10'd0 && y == 10'd0;
   assign frame_end   = x == 10'd0 && y == V_V;
   // scan position delayed to line up with the returning sample
   assign xs      = xd[P-1];
   assign ys      = yd[P-1];
   assign cur     = BASE_V - {2'b00, rd_data};
   assign lvl_row = BASE_V - {2'b00, level};

`ifdef TRACE_INTERP_EN
   logic [9:0] prev_row, prv, lo, hi;
   assign prv = xs == 10'd0 ? cur : prev_row;
   assign lo  = prv < cur ? prv : cur;
   assign hi  = prv < cur ? cur : prv;
   assign hit = ys >= lo && ys <= hi;
   always_ff @(posedge clk) prev_row <= rst ? '0 : cur;
`else
   assign hit = ys == cur;
`endif

   assign trace = state == S_SHOW && xs < DEPTH_V && hit;
   assign vis   = xs < H_V && ys < V_V;
   assign grid  = xs % GRID_V == 10'd0 || ys % GRID_V == 10'd0;
   assign pix   = !vis ? 3'b000 : trace ? 3'b010 : ys == lvl_row ? 3'b100 : grid ? 3'b001 : 3'b000;

   assign hold_capture = state == S_SHOW;
   assign capture_ack  = state == S_ACK;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_EMPTY;
         rd_addr <= '0;
         rgb     <= 3'b000;
         vld     <= '0;
         for (int i = 0; i < P; i++) begin
            xd[i] <= '0;
            yd[i] <= '0;
         end
      end else begin
         state   <= state == S_ACK ? S_EMPTY :
                    state == S_SHOW ? (frame_end ? S_ACK : S_SHOW) :
                    (frame_start && capture_ready ? S_SHOW : S_EMPTY);
         rd_addr <= x < DEPTH_V ? x[ADDR_W-1:0] : '0;
         rgb     <= vld[P-1] ? pix : 3'b000;
         vld     <= {vld[P-2:0], 1'b1};
         xd[0]   <= x;
         yd[0]   <= y;
         for (int i = 1; i < P; i++) begin
            xd[i] <= xd[i-1];
            yd[i] <= yd[i-1];
         end
      end
   end
endmodule
